// File: rtl/led_arbiter.sv
// Three-way fixed-priority owner of the RGB LED with preemption, tick-counted hold and blink engine.
// One-cycle latency req->grant/led (both registered); no backpressure, requesters just hold req.
module led_arbiter #(
   parameter logic [23:0] CLK_DIV    = 24'd12_000_000,
   parameter int          HOLD_TICKS = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [2:0] req,
   input  logic [2:0] color0,
   input  logic [2:0] color1,
   input  logic [2:0] color2,
   input  logic [2:0] blink,
   output logic [2:0] led,
   output logic [2:0] grant,
   output logic       tick
);

   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

   typedef enum logic {IDLE, OWN} state_t;

   state_t        state, state_n;
   logic [23:0]   cnt, cnt_n;
   logic          phase, phase_n;
   logic [HW-1:0] hold, hold_n, hold_inc;
   logic [2:0]    col_l, col_n;
   logic          blk_l, blk_n;
   logic [2:0]    grant_n, led_n, top;
   logic          chg;

   function automatic logic [2:0] top_req(input logic [2:0] r);
      if (r[2])      return 3'b100;
      else if (r[1]) return 3'b010;
      else if (r[0]) return 3'b001;
      else           return 3'b000;
   endfunction

   assign tick = (cnt == CLK_DIV - 24'd1);
   assign top  = top_req(req);

   always_comb begin
      // Hold value as it will stand after this edge, so release lands exactly on the HOLD_TICKS-th tick.
      hold_inc = hold;
      if (tick && hold != HOLD_MAX)
         hold_inc = hold + HW'(1);

      grant_n = grant;
      case (state)
         IDLE: grant_n = top;
         OWN: begin
            // One-hot compare: a numerically larger grant is a higher-priority requester.
            if (top > grant)
               grant_n = top;
            else if ((req & grant) != 3'b000)
               grant_n = grant;
            else if (hold_inc == HOLD_MAX)
               grant_n = top;
         end
         default: grant_n = 3'b000;
      endcase

      state_n = (grant_n != 3'b000) ? OWN : IDLE;
      chg     = (grant_n != grant);

      if (chg) begin
         cnt_n   = 24'd0;
         phase_n = 1'b0;
         hold_n  = '0;
         case (grant_n)
            3'b100:  begin col_n = color2; blk_n = blink[2]; end
            3'b010:  begin col_n = color1; blk_n = blink[1]; end
            3'b001:  begin col_n = color0; blk_n = blink[0]; end
            default: begin col_n = 3'b000; blk_n = 1'b0;     end
         endcase
      end else begin
         cnt_n   = tick ? 24'd0 : cnt + 24'd1;
         phase_n = phase ^ tick;
         hold_n  = hold_inc;
         col_n   = col_l;
         blk_n   = blk_l;
      end

      led_n = 3'b111;
      if (state_n == OWN && !(blk_n && phase_n))
         led_n = ~col_n;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         grant <= 3'b000;
         led   <= 3'b111;
         cnt   <= 24'd0;
         phase <= 1'b0;
         hold  <= '0;
         col_l <= 3'b000;
         blk_l <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         led   <= led_n;
         cnt   <= cnt_n;
         phase <= phase_n;
         hold  <= hold_n;
         col_l <= col_n;
         blk_l <= blk_n;
      end
   end

endmodule
